// File: rtl/instruction_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_unit
//
// Runs ahead of decode by issuing sequential instruction fetches into a small
// circular fetch queue, and restarts fetch at a jump or taken-branch target.
//
// Every queue slot holds a fetch PC, the returned instruction word and a
// filled bit. Three pointers walk the ring:
//   alloc - next slot to reserve when a request is issued
//   fill  - next slot to be written by an in-order memory response
//   head  - slot currently presented to decode
// Each pointer carries one wrap bit above the slot index, so that
// alloc - head (reserved slots) can be told apart for empty (0) and full
// (DEPTH).
//
// A redirect empties the queue at once. Responses to requests that were
// already in flight still come back from memory, so they are counted in
// drop_cnt and discarded as they arrive.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   en                          pipeline enable (0 freezes issue, pop, redirect)
//   jump_target, pc_id,
//   instr_id                    jump request, decode PC, 26-bit index field
//   jump_branch, b_addr         taken-branch request and its target
//   imem_req_valid/addr/ready   fetch request handshake
//   imem_resp_valid/data        in-order fetch responses (never stalled)
//   fq_valid/pc/instr, fq_ready decode-side handshake
//   pc                          next fetch address
// -----------------------------------------------------------------------------
module instruction_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        jump_target,
  input  logic [31:0] pc_id,
  input  logic [25:0] instr_id,
  input  logic        jump_branch,
  input  logic [31:0] b_addr,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fq_valid,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_instr,
  input  logic        fq_ready,
  output logic [31:0] pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Pointers, occupancy and the drop counter all share this width.
  typedef logic [CNT_W-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      pc_q, pc_d;
  ptr_t             alloc_q, alloc_d;
  ptr_t             fill_q, fill_d;
  ptr_t             head_q, head_d;
  ptr_t             drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      slot_pc_q    [DEPTH];
  logic [31:0]      slot_pc_d    [DEPTH];
  logic [31:0]      slot_instr_q [DEPTH];
  logic [31:0]      slot_instr_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode of this cycle's events
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] alloc_idx, fill_idx, head_idx;
  ptr_t             reserved, in_flight;
  logic             redirect, req_fire, resp_accept, resp_drop, pop;
  logic [31:0]      pc_id_next, target;
  logic             unused_pc_id_low;

  assign alloc_idx = alloc_q[PTR_W-1:0];
  assign fill_idx  = fill_q[PTR_W-1:0];
  assign head_idx  = head_q[PTR_W-1:0];

  assign reserved  = alloc_q - head_q;  // slots issued and not yet popped
  assign in_flight = alloc_q - fill_q;  // issued and still awaiting data

  // The jump keeps the 256 MB region of the instruction after the one in
  // decode, which is why the carry out of pc_id + 4 matters.
  assign pc_id_next       = pc_id + 32'd4;
  assign unused_pc_id_low = ^pc_id_next[27:0];

  assign redirect = en & (jump_target | jump_branch);
  assign target   = jump_target ? {pc_id_next[31:28], instr_id, 2'b00} : b_addr;

  // rst_n gating keeps both valids low during reset, before state is defined.
  assign imem_req_valid = rst_n & en & ~redirect & (reserved < DEPTH_P);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses are accepted whatever en is; while stale requests are still
  // draining, everything returned belongs to them.
  assign resp_drop   = imem_resp_valid & (drop_cnt_q != '0);
  assign resp_accept = imem_resp_valid & (drop_cnt_q == '0) & (in_flight != '0);

  assign fq_valid = rst_n & en & filled_q[head_idx];
  assign fq_pc    = slot_pc_q[head_idx];
  assign fq_instr = slot_instr_q[head_idx];
  assign pop      = fq_valid & fq_ready & ~redirect;  // a flush beats a pop

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    pc_d         = pc_q;
    alloc_d      = alloc_q;
    fill_d       = fill_q;
    head_d       = head_q;
    drop_cnt_d   = drop_cnt_q;
    filled_d     = filled_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;

    if (req_fire) begin
      slot_pc_d[alloc_idx] = pc_q;
      alloc_d              = alloc_q + ptr_t'(1);
      pc_d                 = pc_q + 32'd4;
    end

    if (resp_accept) begin
      slot_instr_d[fill_idx] = imem_resp_data;
      filled_d[fill_idx]     = 1'b1;
      fill_d                 = fill_q + ptr_t'(1);
    end

    if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - ptr_t'(1);
    end

    if (pop) begin
      filled_d[head_idx] = 1'b0;
      head_d             = head_q + ptr_t'(1);
    end

    // Redirect overrides everything above. Requests still outstanding after
    // this cycle become drop work: those already being dropped, plus those
    // issued since, less whatever response lands this cycle.
    if (redirect) begin
      pc_d       = target;
      filled_d   = '0;
      alloc_d    = head_q;
      fill_d     = head_q;
      drop_cnt_d = drop_cnt_q - ptr_t'(resp_drop) + in_flight - ptr_t'(resp_accept);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
    end
  end

  // NOTE: slot payload is left unreset; filled_q alone says whether a slot is valid.
  always_ff @(posedge clk) begin
    slot_pc_q    <= slot_pc_d;
    slot_instr_q <= slot_instr_d;
  end

  // A response with nothing outstanding and nothing to drop means the memory
  // side has lost track of requests.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (drop_cnt_q == '0) && (in_flight == '0)));

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_prefetch_unit
//
// Drives instruction_prefetch_unit against a queue-based instruction memory
// (one-cycle latency, can be stalled to hold requests in flight). Expected
// request addresses and decode-side {pc, instr} pairs are pushed to
// scoreboards as each scenario is set up and compared whenever the DUT
// completes the matching handshake. Redirect target arithmetic is covered by
// a table of vectors.
// -----------------------------------------------------------------------------
module tb_instruction_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        jump_target;
  logic [31:0] pc_id;
  logic [25:0] instr_id;
  logic        jump_branch;
  logic [31:0] b_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fq_valid;
  logic [31:0] fq_pc;
  logic [31:0] fq_instr;
  logic        fq_ready;
  logic [31:0] pc;

  logic        mem_stall;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  logic [31:0] exp_req_q [$];
  fq_entry_t   exp_fq_q  [$];
  logic [31:0] mem_q     [$];

  typedef struct {
    logic        en;
    logic        jt;
    logic        jb;
    logic [31:0] pc_id;
    logic [25:0] instr_id;
    logic [31:0] b_addr;
    logic [31:0] exp_pc;
  } redir_vec_t;

  redir_vec_t vecs [7];

  instruction_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .jump_target     (jump_target),
    .pc_id           (pc_id),
    .instr_id        (instr_id),
    .jump_branch     (jump_branch),
    .b_addr          (b_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fq_valid        (fq_valid),
    .fq_pc           (fq_pc),
    .fq_instr        (fq_instr),
    .fq_ready        (fq_ready),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  // Instruction word stored at each address: distinct from the address itself.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Memory: a request accepted at an edge is answered in the following cycle
  // unless stalled; held requests drain one per cycle in order.
  always @(posedge clk) begin : mem_model
    logic [31:0] a;
    if (!rst_n) begin
      mem_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      if (!mem_stall && mem_q.size() > 0) begin
        a = mem_q.pop_front();
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= instr_of(a);
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_fq(input logic [31:0] a);
    exp_fq_q.push_back({a, instr_of(a)});
  endtask

  // Compare every handshake the DUT completes this cycle against the scoreboards.
  task automatic monitor();
    fq_entry_t e;
    if (imem_req_valid && imem_req_ready) begin
      if (exp_req_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL req_unexpected: got request at %h, want none", imem_req_addr);
      end else begin
        check("req_addr", imem_req_addr, exp_req_q.pop_front());
      end
    end
    if (fq_valid && fq_ready) begin
      if (exp_fq_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL pop_unexpected: got pop of pc %h, want none", fq_pc);
      end else begin
        e = exp_fq_q.pop_front();
        check("pop_pc", fq_pc, e.pc);
        check("pop_instr", fq_instr, e.instr);
      end
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1-2 ns later.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check({name, "_req_sb_empty"}, 32'(exp_req_q.size()), 32'd0);
    check({name, "_fq_sb_empty"}, 32'(exp_fq_q.size()), 32'd0);
  endtask

  // Two reset cycles with en high so the output gating is actually exercised.
  task automatic do_reset();
    rst_n          = 1'b0;
    en             = 1'b1;
    jump_target    = 1'b0;
    jump_branch    = 1'b0;
    pc_id          = '0;
    instr_id       = '0;
    b_addr         = '0;
    imem_req_ready = 1'b1;
    fq_ready       = 1'b1;
    mem_stall      = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check1("rst_fq_valid", fq_valid, 1'b0);
      tick();
    end
    #1;
    check("rst_pc", pc, RESET_PC);
    exp_req_q.delete();
    exp_fq_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    //            en    jt    jb    pc_id          instr_id      b_addr         exp_pc
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h1000_0000, 26'h000_0040, 32'h0000_0200, 32'h1000_0100};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h1000_0000, 26'h000_0040, 32'h0000_0200, 32'h0000_0200};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h2FFF_FFFC, 26'h3FF_FFFF, 32'h0000_0000, 32'h3FFF_FFFC};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 26'h000_0001, 32'h0000_0000, 32'h0000_0004};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 26'h000_0000, 32'hDEAD_BEE0, 32'hDEAD_BEE0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 26'h2AA_AAAA, 32'h0000_1234, 32'h8AAA_AAA8};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h1000_0000, 26'h000_0040, 32'h0000_0000, 32'h8AAA_AAA8};

    rst_n          = 1'b0;
    en             = 1'b0;
    jump_target    = 1'b0;
    jump_branch    = 1'b0;
    pc_id          = '0;
    instr_id       = '0;
    b_addr         = '0;
    imem_req_ready = 1'b0;
    fq_ready       = 1'b0;
    mem_stall      = 1'b0;
    @(negedge clk);

    // ---- Streaming fetch with a one-cycle memory ----------------------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_req(32'(4 * i));
      push_fq(32'(4 * i));
    end
    #1;
    check1("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    check1("c0_fq_valid", fq_valid, 1'b0);
    tick();
    #1;
    check1("c1_fq_valid", fq_valid, 1'b0);
    check("c1_req_addr", imem_req_addr, 32'h0000_0004);
    tick();
    #1;
    check1("c2_fq_valid", fq_valid, 1'b1);
    check("c2_req_addr", imem_req_addr, 32'h0000_0008);
    tick();
    repeat (3) tick();
    imem_req_ready = 1'b0;
    repeat (4) tick();
    check_drained("stream");

    // ---- Full queue blocks issue; one pop frees one slot ----------------------
    do_reset();
    fq_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(32'(4 * i));
    for (int c = 0; c < 4; c++) begin
      #1;
      check1("fill_req_valid", imem_req_valid, 1'b1);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      check1("full_req_blocked", imem_req_valid, 1'b0);
      tick();
    end
    push_fq(32'h0000_0000);
    fq_ready = 1'b1;
    #1;
    check1("full_pop_valid", fq_valid, 1'b1);
    check1("full_pop_cycle_req", imem_req_valid, 1'b0);
    tick();
    fq_ready = 1'b0;
    push_req(32'h0000_0010);
    #1;
    check1("after_pop_req_valid", imem_req_valid, 1'b1);
    check("after_pop_req_addr", imem_req_addr, 32'h0000_0010);
    tick();
    #1;
    check1("after_pop_one_only", imem_req_valid, 1'b0);
    tick();
    check_drained("full");

    // ---- Jump with two requests in flight ---------------------------------
    do_reset();
    mem_stall = 1'b1;
    push_req(32'h0000_0000);
    push_req(32'h0000_0004);
    tick();
    tick();
    jump_target = 1'b1;
    pc_id       = 32'h1000_0000;
    instr_id    = 26'h000_0040;
    #1;
    check1("jump_cycle_no_req", imem_req_valid, 1'b0);
    tick();
    jump_target = 1'b0;
    mem_stall   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_req(32'h1000_0100 + 32'(4 * i));
      push_fq(32'h1000_0100 + 32'(4 * i));
    end
    #1;
    check("jump_pc", pc, 32'h1000_0100);
    check1("jump_first_req_valid", imem_req_valid, 1'b1);
    check("jump_first_req_addr", imem_req_addr, 32'h1000_0100);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      check1("stale_dropped_fq_valid", fq_valid, 1'b0);
      tick();
    end
    #1;
    check1("jump_fq_valid", fq_valid, 1'b1);
    check("jump_fq_pc", fq_pc, 32'h1000_0100);
    tick();
    repeat (3) tick();
    imem_req_ready = 1'b0;
    repeat (6) tick();
    exp_req_q.delete();
    exp_fq_q.delete();

    // ---- Redirect target table (memory idle: ready held low) -----------------
    do_reset();
    imem_req_ready = 1'b0;
    fq_ready       = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en          = vecs[i].en;
      jump_target = vecs[i].jt;
      jump_branch = vecs[i].jb;
      pc_id       = vecs[i].pc_id;
      instr_id    = vecs[i].instr_id;
      b_addr      = vecs[i].b_addr;
      #1;
      check1($sformatf("redir%0d_cycle_req", i), imem_req_valid, 1'b0);
      tick();
      en          = 1'b1;
      jump_target = 1'b0;
      jump_branch = 1'b0;
      #1;
      check($sformatf("redir%0d_pc", i), pc, vecs[i].exp_pc);
      check1($sformatf("redir%0d_req_valid", i), imem_req_valid, 1'b1);
      check($sformatf("redir%0d_req_addr", i), imem_req_addr, vecs[i].exp_pc);
    end

    // ---- en low while a response arrives ----------------------------------
    do_reset();
    push_req(32'h0000_0000);
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      jump_target = (c == 1);
      pc_id       = 32'h1000_0000;
      instr_id    = 26'h000_0040;
      #1;
      check("en0_pc", pc, 32'h0000_0004);
      check1("en0_req_valid", imem_req_valid, 1'b0);
      check1("en0_fq_valid", fq_valid, 1'b0);
      tick();
    end
    jump_target    = 1'b0;
    en             = 1'b1;
    imem_req_ready = 1'b0;
    push_fq(32'h0000_0000);
    #1;
    check1("en1_fq_valid", fq_valid, 1'b1);
    check("en1_fq_pc", fq_pc, 32'h0000_0000);
    check("en1_fq_instr", fq_instr, instr_of(32'h0000_0000));
    tick();
    #1;
    check1("en1_after_pop_fq_valid", fq_valid, 1'b0);
    check("en1_pc_held", pc, 32'h0000_0004);
    tick();
    check_drained("en");

    // ---- PC wrap, then reset mid-stream -----------------------------------
    do_reset();
    jump_branch = 1'b1;
    b_addr      = 32'hFFFF_FFF8;
    #1;
    check1("wrap_redirect_req", imem_req_valid, 1'b0);
    tick();
    jump_branch = 1'b0;
    push_req(32'hFFFF_FFF8);
    push_req(32'hFFFF_FFFC);
    push_req(32'h0000_0000);
    push_req(32'h0000_0004);
    push_fq(32'hFFFF_FFF8);
    push_fq(32'hFFFF_FFFC);
    #1;
    check("wrap_pc_fff8", pc, 32'hFFFF_FFF8);
    tick();
    #1;
    check("wrap_pc_fffc", pc, 32'hFFFF_FFFC);
    check1("wrap_req_valid", imem_req_valid, 1'b1);
    tick();
    #1;
    check("wrap_pc_zero", pc, 32'h0000_0000);
    check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check1("midrst_req_valid", imem_req_valid, 1'b0);
    check1("midrst_fq_valid", fq_valid, 1'b0);
    tick();
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    check("midrst_pc", pc, RESET_PC);
    check1("midrst_after_fq_valid", fq_valid, 1'b0);
    tick();
    check_drained("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
